// File: rtl/deser_pkg.sv
// rtl/deser_pkg.sv - shared constants, state type and demux index helper for the deserializer
package deser_pkg;

    localparam int WIDTH = 16;
    localparam int SEL_W = 4;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // Shadow bit position for the cnt-th received bit of a word.
    function automatic logic [SEL_W-1:0] pos_of(input logic [SEL_W-1:0] cnt, input logic msb_first);
        return msb_first ? (SEL_W'(WIDTH - 1) - cnt) : cnt;
    endfunction

endpackage

// File: rtl/demux1to16_reg.sv
// rtl/demux1to16_reg.sv - 16-bit register written one bit at a time through a 1-to-16 demux
module demux1to16_reg
    import deser_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [SEL_W-1:0] sel,
    input  logic             d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '0;
        end else if (we) begin
            q[sel] <= d;
        end
    end

endmodule

// File: rtl/demux1to16_deser.sv
// rtl/demux1to16_deser.sv - bit-serial to 16-bit word deserializer with shadow/output double buffering
module demux1to16_deser
    import deser_pkg::*;
#(
    parameter int WIDTH     = deser_pkg::WIDTH,
    parameter int SEL_W     = deser_pkg::SEL_W,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             frame_sync,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [SEL_W-1:0] bit_count,
    output logic             sync_err
);

    state_t           state, state_n;
    logic [SEL_W-1:0] cnt, cnt_n;
    logic [SEL_W-1:0] idx;
    logic [WIDTH-1:0] shadow, merged, word_n;
    logic             valid_n, sync_err_n, accept;

    assign bit_ready = (state == COLLECT);
    assign bit_count = (state == COLLECT) ? cnt : '0;
    assign accept    = bit_valid & bit_ready;
    // A sync bit always lands in the first slot regardless of the running count.
    assign idx       = pos_of(frame_sync ? '0 : cnt, MSB_FIRST);

    demux1to16_reg u_shadow (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (accept),
        .sel   (idx),
        .d     (bit_in),
        .q     (shadow)
    );

    always_comb begin
        merged      = shadow;
        merged[idx] = bit_in;
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        word_n     = word_out;
        valid_n    = word_valid;
        sync_err_n = 1'b0;
        case (state)
            COLLECT: begin
                if (word_valid && word_ready) begin
                    valid_n = 1'b0;
                end
                if (accept) begin
                    if (frame_sync) begin
                        cnt_n      = SEL_W'(1);
                        sync_err_n = (cnt != '0);
                    end else begin
                        cnt_n = cnt + SEL_W'(1);
                        if (cnt == '1) begin
                            // Output free: load now; otherwise park the full word in shadow.
                            if (!word_valid || word_ready) begin
                                word_n  = merged;
                                valid_n = 1'b1;
                            end else begin
                                state_n = HOLD;
                            end
                        end
                    end
                end
            end
            HOLD: begin
                if (word_ready) begin
                    word_n  = shadow;
                    valid_n = 1'b1;
                    cnt_n   = '0;
                    state_n = COLLECT;
                end
            end
            default: state_n = COLLECT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= COLLECT;
            cnt        <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            word_out   <= word_n;
            word_valid <= valid_n;
            sync_err   <= sync_err_n;
        end
    end

endmodule

// File: tb/tb_demux1to16_deser.sv
// tb/tb_demux1to16_deser.sv - scoreboard bench for demux1to16_deser, LSB-first and MSB-first instances
module tb_demux1to16_deser;

    logic        clk = 1'b0;
    logic        rst_n, bit_in, bit_valid, frame_sync, word_ready;
    logic        bit_ready, word_valid, sync_err;
    logic        bit_ready_m, word_valid_m, sync_err_m;
    logic [15:0] word_out, word_out_m;
    logic [3:0]  bit_count, bit_count_m;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int serr_cnt = 0;
    int b2b_stall = 0;
    logic in_b2b = 1'b0;
    logic [15:0] sb[$];
    int          pop_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    demux1to16_deser #(.MSB_FIRST(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready),
        .frame_sync(frame_sync), .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .bit_count(bit_count), .sync_err(sync_err)
    );

    demux1to16_deser #(.MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .bit_in(bit_in), .bit_valid(bit_valid), .bit_ready(bit_ready_m),
        .frame_sync(frame_sync), .word_out(word_out_m), .word_valid(word_valid_m), .word_ready(word_ready),
        .bit_count(bit_count_m), .sync_err(sync_err_m)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [15:0] rev16(input logic [15:0] w);
        logic [15:0] r;
        for (int i = 0; i < 16; i++) r[i] = w[15-i];
        return r;
    endfunction

    // Consumer side: a word is taken whenever valid and ready coincide at an edge.
    always @(negedge clk) begin
        logic [15:0] exp;
        if (in_b2b && !bit_ready) b2b_stall++;
        if (sync_err) serr_cnt++;
        if (rst_n && word_valid && word_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", sb.size(), 1);
            end else begin
                exp = sb.pop_front();
                check("word_lsb", word_out, exp);
                check("word_msb", word_out_m, rev16(exp));
                check("valid_msb", word_valid_m, 1);
                pop_cyc.push_back(cyc);
            end
        end
    end

    // Entered and left at posedge+1; holds the bit until an edge sees bit_ready high.
    task automatic send_bit(input logic b, input logic fs);
        int   budget = 0;
        logic r;
        bit_in     = b;
        bit_valid  = 1'b1;
        frame_sync = fs;
        do begin
            @(negedge clk);
            r = bit_ready;
            @(posedge clk);
            budget++;
        end while (!r && budget < 200);
        if (!r) check("bit_accept_timeout", 0, 1);
        #1;
        frame_sync = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        sb.push_back(w);
        for (int i = 0; i < 16; i++) send_bit(w[i], 1'b0);
    endtask

    task automatic idle(input int n);
        bit_valid  = 1'b0;
        frame_sync = 1'b0;
        for (int i = 0; i < n; i++) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        rst_n = 1'b0; bit_in = 1'b0; bit_valid = 1'b0; frame_sync = 1'b0; word_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_word_valid", word_valid, 0);
        check("rst_bit_ready", bit_ready, 1);
        check("rst_bit_count", bit_count, 0);
        check("rst_word_out", word_out, 0);
        check("rst_sync_err", sync_err, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Single word, consumer always ready
        word_ready = 1'b1;
        send_word(16'hA5C3);
        bit_valid = 1'b0;
        @(negedge clk);
        check("t1_latency_valid", word_valid, 1);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_pulse_end", word_valid, 0);
        check("t1_bit_count", bit_count, 0);
        @(posedge clk); #1;

        // Backpressure: two words with no consumer
        word_ready = 1'b0;
        send_word(16'h1234);
        send_word(16'hBEEF);
        bit_valid = 1'b0;
        @(negedge clk);
        check("bp_bit_ready_hold", bit_ready, 0);
        check("bp_word_out_hold", word_out, 16'h1234);
        check("bp_word_valid", word_valid, 1);
        check("bp_bit_count_hold", bit_count, 0);
        @(posedge clk); #1;
        word_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_in_pulse", bit_ready, 0);
        @(posedge clk); #1;
        word_ready = 1'b0;
        @(negedge clk);
        check("bp_second_word", word_out, 16'hBEEF);
        check("bp_second_valid", word_valid, 1);
        check("bp_bit_ready_back", bit_ready, 1);
        @(posedge clk); #1;
        word_ready = 1'b1;
        idle(2);

        // Frame resync after a 5-bit partial
        serr_cnt = 0;
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0); send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0); send_bit(1'b0, 1'b0);
        w = 16'h00FF;
        sb.push_back(w);
        send_bit(w[0], 1'b1);
        for (int i = 1; i < 16; i++) send_bit(w[i], 1'b0);
        idle(3);
        check("resync_err_pulses", serr_cnt, 1);

        // Back-to-back drain
        pop_cyc.delete();
        b2b_stall = 0;
        in_b2b = 1'b1;
        send_word(16'h0001);
        send_word(16'h8000);
        send_word(16'hFFFF);
        bit_valid = 1'b0;
        in_b2b = 1'b0;
        idle(3);
        check("b2b_word_count", pop_cyc.size(), 3);
        if (pop_cyc.size() == 3) begin
            check("b2b_gap1", pop_cyc[1] - pop_cyc[0], 16);
            check("b2b_gap2", pop_cyc[2] - pop_cyc[1], 16);
        end
        check("b2b_no_stall", b2b_stall, 0);
        check("b2b_no_sync_err", serr_cnt, 1);

        // Reset with a word held and a partial in progress
        word_ready = 1'b0;
        send_word(16'h1111);
        for (int i = 0; i < 9; i++) send_bit(i[0], 1'b0);
        bit_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_bit_count", bit_count, 9);
        check("pre_rst_valid", word_valid, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        sb.delete();
        @(negedge clk);
        check("mid_rst_word_valid", word_valid, 0);
        check("mid_rst_bit_count", bit_count, 0);
        check("mid_rst_bit_ready", bit_ready, 1);
        check("mid_rst_word_out", word_out, 0);
        check("mid_rst_word_out_m", word_out_m, 0);
        @(posedge clk); #1;
        word_ready = 1'b1;
        send_word(16'h5A5A);
        idle(3);
        check("sb_drained", sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
